// File: rtl/ram_pkg.sv
// ram_pkg: shared FSM state type and default geometry for the dual-port RAM.
package ram_pkg;
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ram_state_e;
  localparam int DEF_DATA_SIZE    = 32;
  localparam int DEF_ADDRESS_SIZE = 16;
  localparam int DEF_DEPTH        = 1024;
endpackage

// File: rtl/ram_clear_sequencer.sv
// ram_clear_sequencer: post-reset zeroing sweep and CLEAR/RUN FSM.
module ram_clear_sequencer
  import ram_pkg::*;
#(
  parameter int DEPTH          = DEF_DEPTH,
  parameter int CLEAR_ON_RESET = 1,
  parameter int IW             = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [IW-1:0] clr_addr_o,
  output logic          clr_we_o,
  output logic          ready_o
);
  ram_state_e    state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          clearing;
  assign clearing = (state_q == ST_CLEAR) && (CLEAR_ON_RESET != 0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // Without clearing, CLEAR lasts exactly one edge and touches nothing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      state_d = (!clearing || cnt_q == IW'(DEPTH - 1)) ? ST_RUN : ST_CLEAR;
      cnt_d   = clearing ? cnt_q + 1'b1 : cnt_q;
    end
  end
  always_comb begin
    clr_we_o   = clearing;
    clr_addr_o = cnt_q;
    ready_o    = (state_q == ST_RUN);
  end
endmodule

// File: rtl/dual_port_ram.sv
// dual_port_ram: byte-enabled data port plus independent fetch port, latency-1
// registered reads, write-through to fetch, optional zeroing sweep after reset.
module dual_port_ram
  import ram_pkg::*;
#(
  parameter int DATA_SIZE      = DEF_DATA_SIZE,
  parameter int ADDRESS_SIZE   = DEF_ADDRESS_SIZE,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    read_write,
  input  logic [ADDRESS_SIZE-1:0] address,
  input  logic [DATA_SIZE-1:0]    data_in,
  input  logic [DATA_SIZE/8-1:0]  byte_en,
  output logic [DATA_SIZE-1:0]    data_out,
  output logic                    data_valid,
  input  logic                    fetch_enable,
  input  logic [ADDRESS_SIZE-1:0] fetch_address,
  output logic [DATA_SIZE-1:0]    fetch_out,
  output logic                    fetch_valid,
  output logic                    ready,
  output logic                    addr_error
);
  localparam int NB = DATA_SIZE / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRESS_SIZE:0] DEPTH_A = (ADDRESS_SIZE + 1)'(DEPTH);

  if (DATA_SIZE % 8 != 0 || DEPTH > (1 << ADDRESS_SIZE)) begin : g_bad_params
    $error("dual_port_ram: DATA_SIZE must be a multiple of 8 and DEPTH <= 2**ADDRESS_SIZE");
  end

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [DATA_SIZE-1:0] data_out_q, data_out_d, fetch_out_q, fetch_out_d, merged;
  logic                 data_valid_q, data_valid_d, fetch_valid_q, fetch_valid_d;
  logic                 addr_error_q, addr_error_d;
  logic [IW-1:0]        clr_addr, d_idx, f_idx;
  logic                 clr_we, d_in, f_in, d_req, f_req, rd, wr_en;

  ram_clear_sequencer #(
    .DEPTH          (DEPTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET),
    .IW             (IW)
  ) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_addr_o (clr_addr),
    .clr_we_o   (clr_we),
    .ready_o    (ready)
  );

  always_comb begin
    d_in  = {1'b0, address} < DEPTH_A;
    f_in  = {1'b0, fetch_address} < DEPTH_A;
    d_idx = address[IW-1:0];
    f_idx = fetch_address[IW-1:0];
    d_req = ready && enable;
    f_req = ready && fetch_enable;
    rd    = d_req && read_write;
    wr_en = d_req && !read_write && d_in;
    merged = mem[d_idx];
    for (int b = 0; b < NB; b++)
      merged[8*b +: 8] = byte_en[b] ? data_in[8*b +: 8] : merged[8*b +: 8];
    data_out_d    = rd ? (d_in ? mem[d_idx] : '0) : data_out_q;
    // A same-cycle write to the fetched word is forwarded so fetch sees new data.
    fetch_out_d   = f_req ? (!f_in ? '0 : (wr_en && f_idx == d_idx) ? merged : mem[f_idx])
                          : fetch_out_q;
    data_valid_d  = rd;
    fetch_valid_d = f_req;
    addr_error_d  = (d_req && !d_in) || (f_req && !f_in);
  end

  always_ff @(posedge clk) begin
    if (clr_we)
      mem[clr_addr] <= '0;
    else if (wr_en)
      mem[d_idx] <= merged;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q    <= '0;
      fetch_out_q   <= '0;
      data_valid_q  <= 1'b0;
      fetch_valid_q <= 1'b0;
      addr_error_q  <= 1'b0;
    end else begin
      data_out_q    <= data_out_d;
      fetch_out_q   <= fetch_out_d;
      data_valid_q  <= data_valid_d;
      fetch_valid_q <= fetch_valid_d;
      addr_error_q  <= addr_error_d;
    end
  end

  assign data_out    = data_out_q;
  assign fetch_out   = fetch_out_q;
  assign data_valid  = data_valid_q;
  assign fetch_valid = fetch_valid_q;
  assign addr_error  = addr_error_q;
endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram: directed scenario tasks for dual_port_ram with 32-bit words, 16-word depth.
module tb_dual_port_ram;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0, read_write = 1'b0, fetch_enable = 1'b0;
  logic [AW-1:0] address = '0, fetch_address = '0;
  logic [DW-1:0] data_in = '0;
  logic [DW/8-1:0] byte_en = '0;
  logic [DW-1:0] data_out, fetch_out;
  logic          data_valid, fetch_valid, ready, addr_error;
  int checks = 0;
  int errors = 0;

  dual_port_ram #(
    .DATA_SIZE(DW), .ADDRESS_SIZE(AW), .DEPTH(DEPTH), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .read_write(read_write),
    .address(address), .data_in(data_in), .byte_en(byte_en),
    .data_out(data_out), .data_valid(data_valid),
    .fetch_enable(fetch_enable), .fetch_address(fetch_address),
    .fetch_out(fetch_out), .fetch_valid(fetch_valid),
    .ready(ready), .addr_error(addr_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable = 1'b0;
    fetch_enable = 1'b0;
    read_write = 1'b0;
    byte_en = '0;
  endtask

  task automatic test_reset();
    logic saw_valid = 1'b0;
    logic saw_err = 1'b0;
    #1;
    checks++;
    if ({data_out, fetch_out, data_valid, fetch_valid, addr_error, ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got do=%h fo=%h dv=%b fv=%b ae=%b rdy=%b, expected all 0",
               data_out, fetch_out, data_valid, fetch_valid, addr_error, ready);
    end
    tick();
    tick();
    // Write to addr 2 and fetch throughout CLEAR; all of it must be ignored.
    enable = 1'b1; read_write = 1'b0; address = 8'd2; data_in = 32'hFFFF_FFFF; byte_en = 4'hF;
    fetch_enable = 1'b1; fetch_address = 8'd2;
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      saw_valid |= data_valid | fetch_valid;
      saw_err |= addr_error;
      if (i == 15) begin
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL ready_early: got %b expected 0", ready); end
      end
      if (i == 16) begin
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL ready_at_16: got %b expected 1", ready); end
      end
    end
    idle();
    checks++;
    if ({saw_valid, saw_err} !== 2'b00) begin
      errors++;
      $display("FAIL clear_ignore_strobes: got valid=%b err=%b expected 0 0", saw_valid, saw_err);
    end
  endtask

  task automatic test_cleared_contents();
    enable = 1'b1; read_write = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      address = AW'(a);
      tick();
      checks++;
      if (data_out !== 32'h0 || data_valid !== 1'b1) begin
        errors++;
        $display("FAIL clear_read[%0d]: got %h valid=%b expected 00000000 valid=1", a, data_out, data_valid);
      end
    end
    idle();
  endtask

  task automatic test_byte_enable();
    enable = 1'b1; read_write = 1'b0; address = 8'd3; data_in = 32'hDEAD_BEEF; byte_en = 4'b1111;
    tick();
    data_in = 32'h1122_3344; byte_en = 4'b0101;
    tick();
    checks++;
    if (data_valid !== 1'b0) begin errors++; $display("FAIL write_no_valid: got %b expected 0", data_valid); end
    data_in = 32'h0; byte_en = 4'b0000;
    tick();
    read_write = 1'b1;
    tick();
    checks++;
    if (data_out !== 32'hDE22_BE44 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL byte_merge: got %h valid=%b expected de22be44 valid=1", data_out, data_valid);
    end
    idle();
    tick();
    checks++;
    if (data_out !== 32'hDE22_BE44 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_data_out: got %h valid=%b expected de22be44 valid=0", data_out, data_valid);
    end
  endtask

  task automatic test_write_through();
    enable = 1'b1; read_write = 1'b0; address = 8'd5; data_in = 32'hCAFE_F00D; byte_en = 4'hF;
    fetch_enable = 1'b1; fetch_address = 8'd5;
    tick();
    checks++;
    if (fetch_out !== 32'hCAFE_F00D || fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL write_through: got %h valid=%b expected cafef00d valid=1", fetch_out, fetch_valid);
    end
    read_write = 1'b1; address = 8'd3; byte_en = '0;
    tick();
    checks++;
    if (data_out !== 32'hDE22_BE44 || fetch_out !== 32'hCAFE_F00D || data_valid !== 1'b1 || fetch_valid !== 1'b1) begin
      errors++;
      $display("FAIL concurrent_read: got do=%h fo=%h dv=%b fv=%b expected de22be44 cafef00d 1 1",
               data_out, fetch_out, data_valid, fetch_valid);
    end
    address = 8'd5;
    tick();
    checks++;
    if (data_out !== 32'hCAFE_F00D || fetch_out !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL same_addr_read: got do=%h fo=%h expected cafef00d cafef00d", data_out, fetch_out);
    end
    idle();
    tick();
    checks++;
    if (fetch_out !== 32'hCAFE_F00D || fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_fetch_out: got %h valid=%b expected cafef00d valid=0", fetch_out, fetch_valid);
    end
  endtask

  task automatic test_out_of_range();
    enable = 1'b1; read_write = 1'b1; address = 8'd20;
    tick();
    checks++;
    if (data_out !== 32'h0 || data_valid !== 1'b1 || addr_error !== 1'b1) begin
      errors++;
      $display("FAIL oor_read: got %h valid=%b err=%b expected 00000000 1 1", data_out, data_valid, addr_error);
    end
    idle();
    tick();
    checks++;
    if (addr_error !== 1'b0) begin errors++; $display("FAIL oor_pulse: got %b expected 0", addr_error); end
    // Address 20 aliases word 4 in its low bits; the write must not land there.
    enable = 1'b1; read_write = 1'b0; address = 8'd20; data_in = 32'h1234_5678; byte_en = 4'hF;
    tick();
    checks++;
    if (addr_error !== 1'b1) begin errors++; $display("FAIL oor_write_err: got %b expected 1", addr_error); end
    read_write = 1'b1; address = 8'd4; byte_en = '0;
    tick();
    checks++;
    if (data_out !== 32'h0 || addr_error !== 1'b0) begin
      errors++;
      $display("FAIL oor_write_dropped: got %h err=%b expected 00000000 0", data_out, addr_error);
    end
    idle();
    fetch_enable = 1'b1; fetch_address = 8'd30;
    tick();
    checks++;
    if (fetch_out !== 32'h0 || fetch_valid !== 1'b1 || addr_error !== 1'b1) begin
      errors++;
      $display("FAIL oor_fetch: got %h valid=%b err=%b expected 00000000 1 1", fetch_out, fetch_valid, addr_error);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_clear();
    enable = 1'b1; read_write = 1'b1; address = 8'd3;
    fetch_enable = 1'b1; fetch_address = 8'd5;
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({data_out, fetch_out, data_valid, fetch_valid, addr_error, ready} !== '0) begin
      errors++;
      $display("FAIL async_reset_run: got do=%h fo=%h dv=%b fv=%b ae=%b rdy=%b expected all 0",
               data_out, fetch_out, data_valid, fetch_valid, addr_error, ready);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || data_out !== '0 || fetch_out !== '0) begin
      errors++;
      $display("FAIL reset_mid_clear: got rdy=%b do=%h fo=%h expected 0 0 0", ready, data_out, fetch_out);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) begin
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL restart_ready_early: got %b expected 0", ready); end
      end
      if (i == 16) begin
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL restart_ready_16: got %b expected 1", ready); end
      end
    end
    enable = 1'b1; read_write = 1'b1; address = 8'd3;
    fetch_enable = 1'b1; fetch_address = 8'd5;
    tick();
    checks++;
    if (data_out !== 32'h0 || fetch_out !== 32'h0 || data_valid !== 1'b1) begin
      errors++;
      $display("FAIL recleared: got do=%h fo=%h dv=%b expected 0 0 1", data_out, fetch_out, data_valid);
    end
    idle();
    tick();
  endtask

  initial begin
    test_reset();
    test_cleared_contents();
    test_byte_enable();
    test_write_through();
    test_out_of_range();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_port_ram.md
DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 32, data word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDRESS_SIZE, default 16, address port width.
REQ-003 SHALL have parameter DEPTH, default 1024, number of words (DEPTH <= 2**ADDRESS_SIZE).
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1, 1 = zero all words after reset.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port enable  in  1  data-port request strobe.
REQ-008 SHALL have port read_write  in  1  1 = read, 0 = write.
REQ-009 SHALL have port address  in  ADDRESS_SIZE  data-port word address.
REQ-010 SHALL have port data_in  in  DATA_SIZE  write data.
REQ-011 SHALL have port byte_en  in  DATA_SIZE/8  per-byte write enable, bit i covers data_in[8i+7:8i].
REQ-012 SHALL have port data_out  out  DATA_SIZE  registered read data.
REQ-013 SHALL have port data_valid  out  1  one-cycle pulse, data_out updated.
REQ-014 SHALL have port fetch_enable  in  1  fetch-port read strobe.
REQ-015 SHALL have port fetch_address  in  ADDRESS_SIZE  fetch-port word address.
REQ-016 SHALL have port fetch_out  out  DATA_SIZE  registered fetch data.
REQ-017 SHALL have port fetch_valid  out  1  one-cycle pulse, fetch_out updated.
REQ-018 SHALL have port ready  out  1  high when requests are accepted.
REQ-019 SHALL have port addr_error  out  1  one-cycle pulse on out-of-range access, either port.

Function
REQ-020 SHALL run a two-state FSM: CLEAR and RUN.
REQ-021 SHALL, in CLEAR, write zero to word k on the k-th cycle after reset release, k = 0..DEPTH-1, then enter RUN; ready = 0 throughout CLEAR.
REQ-022 SHALL, with CLEAR_ON_RESET = 0, enter RUN on the first clock edge after reset release without touching memory.
REQ-023 SHALL ignore enable and fetch_enable while ready = 0 (no write, no valid pulse, no addr_error).
REQ-024 SHALL, on enable=1 & read_write=0 in RUN, update only byte lanes with byte_en=1 at that rising edge; byte_en = 0 yields no change.
REQ-025 SHALL, on enable=1 & read_write=1 in RUN, present mem[address] on data_out and pulse data_valid on the following cycle (latency 1).
REQ-026 SHALL serve fetch_enable independently and concurrently with the data port, latency 1, via fetch_out/fetch_valid.
REQ-027 SHALL, when a write and a fetch target the same address in the same cycle, return the post-write merged word on fetch_out (write-through).
REQ-028 SHALL hold data_out and fetch_out at their last values when no read is issued.
REQ-029 SHALL treat address >= DEPTH as out of range: write dropped, read returns zero with valid pulse, addr_error pulses next cycle.
REQ-030 SHALL let both ports read the same address in one cycle, each returning the same word.

Reset
REQ-031 SHALL, on rst_n low, immediately clear data_out, fetch_out, data_valid, fetch_valid, addr_error, ready to 0 and the clear counter to 0.
REQ-032 SHALL, on rst_n asserted mid-CLEAR or mid-RUN, abort and restart in CLEAR (or RUN if CLEAR_ON_RESET = 0) on release.
REQ-033 SHALL not reset memory contents asynchronously; zeroing occurs only via CLEAR.

Structure
REQ-034 SHALL place the FSM state enum and parameter defaults (DATA_SIZE, ADDRESS_SIZE, DEPTH) in shared package ram_pkg.
REQ-035 SHALL implement the CLEAR counter and FSM in sub-module ram_clear_sequencer, supplying clear address, clear write strobe and ready.
REQ-036 SHALL fail elaboration if DATA_SIZE % 8 != 0 or DEPTH > 2**ADDRESS_SIZE.

Verification (bench: DATA_SIZE=32, ADDRESS_SIZE=8, DEPTH=16)
REQ-037 SHALL check: release rst_n -> ready rises exactly 16 cycles later; reads of addr 0..15 return 0x00000000.
REQ-038 SHALL check: write 0xDEADBEEF byte_en=4'b1111 addr 3, then write 0x11223344 byte_en=4'b0101 addr 3, read addr 3 -> 0xDE22BE44 one cycle later with data_valid pulse.
REQ-039 SHALL check: same cycle write 0xCAFEF00D addr 5 and fetch addr 5 -> fetch_out = 0xCAFEF00D next cycle; concurrent data read addr 3 -> 0xDE22BE44.
REQ-040 SHALL check: read addr 20 -> data_out = 0, data_valid = 1, addr_error = 1; write addr 20 -> memory unchanged, addr_error = 1.
REQ-041 SHALL check: assert rst_n low at clear cycle 7 -> all outputs 0 immediately; after release ready rises 16 cycles later.
REQ-042 SHALL check: enable=1 during CLEAR -> no data_valid, write ignored (word reads 0 after ready).
